// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, no parity.
// Mid-bit sampling is timed from the detected start edge with a per-bit counter.
// A framing error parks the FSM in BRK until the line returns high.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | counting to the middle of the start bit to confirm it
// DATA  | sampling the 8 data bits at mid-bit
// STOP  | sampling the stop bit, then completing or rejecting the byte
// BRK   | stop bit was low; wait for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_s_d;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Receive FSM with the output handshake; completion at the stop edge overrides the consume-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s && rx_s_d) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 16 clocks per bit. Stimulus pushes expected output
// events (byte load, framing error, overrun) with their cycle; the monitor pops
// and compares whenever the DUT shows one of those events.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int K_LD = 0;
    localparam int K_FE = 1;
    localparam int K_OV = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       prev_v = 1'b0;
    logic [7:0] prev_d = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic observe(input int k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h at cycle %0d, expected none", k, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k != K_FE && e.data !== d) || e.at != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d data %0h cycle %0d, expected kind %0d data %0h cycle %0d",
                         k, d, cyc, e.kind, e.data, e.at);
            end
        end
    endtask

    // Monitor: every frame_err, overrun or fresh byte on rx_data is matched against the queue.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_err) observe(K_FE, rx_data);
            if (overrun) observe(K_OV, rx_data);
            if (rx_valid && (!prev_v || rx_data !== prev_d)) observe(K_LD, rx_data);
        end
        prev_v = rx_valid;
        prev_d = rx_data;
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drives one full frame starting at a negedge. The stop edge is 155 posedges
    // after the start-bit drive: 3 for synchronizer + edge detect, then 8 + 9*16.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit ready_pulse,
                              input int kind, input logic [7:0] edata);
        int n;
        int bv;
        n = cyc;
        if (kind >= 0) exp_q.push_back('{kind, edata, n + 155});
        for (int j = 0; j < 10 * CPB; j++) begin
            bv = j / CPB;
            if (bv == 0) rx = 1'b0;
            else if (bv == 9) rx = stop;
            else rx = b[bv-1];
            if (ready_pulse && j == 154) rx_ready = 1'b1;
            if (ready_pulse && j == 155) rx_ready = 1'b0;
            @(negedge clk);
        end
        if (stop) rx = 1'b1;
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        // reset state
        wait_neg(3);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        wait_neg(5);

        // good byte, consumer ready
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, K_LD, 8'hA5);
        wait_neg(2);
        check("a5_valid_one_cycle", rx_valid, 0);
        check("a5_busy_idle", busy, 0);
        check_drained("a5_drained");

        // false start: 5 low cycles
        rx = 1'b0;
        wait_neg(5);
        rx = 1'b1;
        wait_neg(5);
        check("false_start_busy_before", busy, 1);
        wait_neg(1);
        check("false_start_busy_after", busy, 0);
        wait_neg(20);
        check("false_start_no_valid", rx_valid, 0);
        check_drained("false_start_drained");

        // framing error then line held low (break)
        send_frame(8'h3C, 1'b0, 1'b0, K_FE, 8'h00);
        check("brk_busy_entry", busy, 1);
        wait_neg(10);
        check("brk_busy_held", busy, 1);
        rx = 1'b1;
        wait_neg(2);
        check("brk_busy_before_exit", busy, 1);
        wait_neg(1);
        check("brk_busy_exit", busy, 0);
        check("brk_no_valid", rx_valid, 0);
        wait_neg(5);
        check_drained("brk_drained");

        // overrun: consumer stalled, two bytes
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, K_LD, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0, K_OV, 8'h11);
        wait_neg(2);
        check("ovr_rx_data_held", rx_data, 8'h11);
        check("ovr_rx_valid", rx_valid, 1);
        check_drained("ovr_drained");
        rx_ready = 1'b1;
        wait_neg(1);
        rx_ready = 1'b0;
        check("ovr_consumed", rx_valid, 0);

        // consume and reload on the same edge
        send_frame(8'h55, 1'b1, 1'b0, K_LD, 8'h55);
        send_frame(8'h66, 1'b1, 1'b1, K_LD, 8'h66);
        wait_neg(2);
        check("reload_rx_data", rx_data, 8'h66);
        check("reload_rx_valid", rx_valid, 1);
        check_drained("reload_drained");

        // reset in the middle of a frame of 8'hFF
        rx = 1'b0;
        wait_neg(CPB);
        rx = 1'b1;
        wait_neg(30);
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_busy", busy, 0);
        wait_neg(4);
        reset = 1'b1;
        wait_neg(CPB * 12);
        check("post_rst_no_restart", busy, 0);
        check("post_rst_no_valid", rx_valid, 0);
        rx_ready = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b0, K_LD, 8'h0F);
        wait_neg(2);
        check("post_rst_consumed", rx_valid, 0);
        check("post_rst_rx_data", rx_data, 8'h0F);
        check_drained("final_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
